// File: rtl/uart_apb_cmd_ctrl.sv
`timescale 1ns/1ps
// uart_apb_cmd_ctrl
//   Turns byte frames from a UART receiver into single APB transfers and
//   returns a status/data response on the UART transmit byte interface.
//     Write frame : 0x57, ADDR, D0, D1, D2, D3  -> 0x06 (OK) / 0x15 (pslverr)
//     Read frame  : 0x52, ADDR                  -> 4 data bytes + 0x06 / 0x15
//   paddr = zero-extended {ADDR, 2'b00}.
//
// Ports
//   bb_clk_in          system clock
//   key0               asynchronous active-low reset
//   rx_valid/rx_data   received byte strobe (no backpressure)
//   tx_data/tx_valid/  response byte stream, valid held until tx_ready
//   tx_ready
//   paddr/psel/penable/pwrite/pwdata/prdata/pready/pslverr   APB master
//   busy               high whenever the sequencer is not idle
//   frame_err          one-cycle pulse on timeout, bad opcode or dropped byte
//
// Build option
//   UART_CMD_PREADY_TO_EN : abort an APB access after PREADY_TIMEOUT cycles
//                           without pready and answer 0x15.
module uart_apb_cmd_ctrl #(
  parameter int PADDR_W        = 12,
  parameter int TIMEOUT_CYCLES = 10000,
  parameter int PREADY_TIMEOUT = 255
) (
  input  logic               bb_clk_in,
  input  logic               key0,
  input  logic               rx_valid,
  input  logic [7:0]         rx_data,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic [PADDR_W-1:0] paddr,
  output logic               psel,
  output logic               penable,
  output logic               pwrite,
  output logic [31:0]        pwdata,
  input  logic [31:0]        prdata,
  input  logic               pready,
  input  logic               pslverr,
  output logic               busy,
  output logic               frame_err
);

  localparam logic [7:0] CMD_WR = 8'h57;
  localparam logic [7:0] CMD_RD = 8'h52;
  localparam logic [7:0] ACK    = 8'h06;
  localparam logic [7:0] NAK    = 8'h15;

  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_ADDR,
    S_GET_DATA,
    S_APB_SETUP,
    S_APB_ACCESS,
    S_SEND
  } state_e;

  state_e             state_q, state_d;
  logic               pwrite_q, pwrite_d;
  logic [7:0]         addr_q, addr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic [1:0]         bcnt_q, bcnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  // Response bytes, byte 0 in bits [7:0]; rlen is the byte count to send.
  logic [39:0]        resp_q, resp_d;
  logic [2:0]         rlen_q, rlen_d;
  logic [2:0]         ridx_q, ridx_d;
  logic               ferr_q, ferr_d;

`ifdef UART_CMD_PREADY_TO_EN
  localparam int               PTO_W    = $clog2(PREADY_TIMEOUT + 1);
  localparam logic [PTO_W-1:0] PTO_LAST = PTO_W'(PREADY_TIMEOUT - 1);
  logic [PTO_W-1:0]   pto_q, pto_d;
`endif

  always_ff @(posedge bb_clk_in or negedge key0) begin
    if (!key0) begin
      state_q  <= S_IDLE;
      pwrite_q <= 1'b0;
      addr_q   <= '0;
      pwdata_q <= '0;
      bcnt_q   <= '0;
      tmo_q    <= '0;
      resp_q   <= '0;
      rlen_q   <= '0;
      ridx_q   <= '0;
      ferr_q   <= 1'b0;
`ifdef UART_CMD_PREADY_TO_EN
      pto_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pwrite_q <= pwrite_d;
      addr_q   <= addr_d;
      pwdata_q <= pwdata_d;
      bcnt_q   <= bcnt_d;
      tmo_q    <= tmo_d;
      resp_q   <= resp_d;
      rlen_q   <= rlen_d;
      ridx_q   <= ridx_d;
      ferr_q   <= ferr_d;
`ifdef UART_CMD_PREADY_TO_EN
      pto_q    <= pto_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    pwrite_d = pwrite_q;
    addr_d   = addr_q;
    pwdata_d = pwdata_q;
    bcnt_d   = bcnt_q;
    tmo_d    = tmo_q;
    resp_d   = resp_q;
    rlen_d   = rlen_q;
    ridx_d   = ridx_q;
    ferr_d   = 1'b0;
`ifdef UART_CMD_PREADY_TO_EN
    pto_d    = pto_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WR || rx_data == CMD_RD) begin
            pwrite_d = (rx_data == CMD_WR);
            tmo_d    = '0;
            bcnt_d   = '0;
            state_d  = S_GET_ADDR;
          end else begin
            ferr_d  = 1'b1;
            resp_d  = {32'h0, NAK};
            rlen_d  = 3'd1;
            ridx_d  = '0;
            state_d = S_SEND;
          end
        end
      end

      // A byte arriving on the expiry cycle takes priority over the timeout.
      S_GET_ADDR: begin
        if (rx_valid) begin
          addr_d  = rx_data;
          tmo_d   = '0;
          state_d = pwrite_q ? S_GET_DATA : S_APB_SETUP;
        end else if (tmo_q == TMO_LAST) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_GET_DATA: begin
        if (rx_valid) begin
          pwdata_d[{bcnt_q, 3'b000} +: 8] = rx_data;
          bcnt_d = bcnt_q + 1'b1;
          tmo_d  = '0;
          if (bcnt_q == 2'd3) state_d = S_APB_SETUP;
        end else if (tmo_q == TMO_LAST) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      S_APB_SETUP: begin
        ferr_d  = rx_valid;
`ifdef UART_CMD_PREADY_TO_EN
        pto_d   = '0;
`endif
        state_d = S_APB_ACCESS;
      end

      S_APB_ACCESS: begin
        ferr_d = rx_valid;
        if (pready) begin
          ridx_d  = '0;
          state_d = S_SEND;
          if (pslverr) begin
            resp_d = {32'h0, NAK};
            rlen_d = 3'd1;
          end else if (pwrite_q) begin
            resp_d = {32'h0, ACK};
            rlen_d = 3'd1;
          end else begin
            resp_d = {ACK, prdata};
            rlen_d = 3'd5;
          end
        end
`ifdef UART_CMD_PREADY_TO_EN
        else if (pto_q == PTO_LAST) begin
          ferr_d  = 1'b1;
          resp_d  = {32'h0, NAK};
          rlen_d  = 3'd1;
          ridx_d  = '0;
          state_d = S_SEND;
        end else begin
          pto_d = pto_q + 1'b1;
        end
`endif
      end

      S_SEND: begin
        ferr_d = rx_valid;
        if (tx_ready) begin
          if (ridx_q == rlen_q - 3'd1) state_d = S_IDLE;
          else                         ridx_d  = ridx_q + 3'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign psel      = (state_q == S_APB_SETUP) || (state_q == S_APB_ACCESS);
  assign penable   = (state_q == S_APB_ACCESS);
  assign pwrite    = pwrite_q;
  assign pwdata    = pwdata_q;
  assign paddr     = PADDR_W'({addr_q, 2'b00});
  assign tx_valid  = (state_q == S_SEND);
  assign tx_data   = (state_q == S_SEND) ? 8'(resp_q >> {ridx_q, 3'b000}) : 8'h00;
  assign busy      = (state_q != S_IDLE);
  assign frame_err = ferr_q;

endmodule
